// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer: op codes, FSM states and
// command-table entry layout.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    OP_END = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_DLY = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWait,
    StGap,
    StDly,
    StNext,
    StDone,
    StError
  } state_e;

  // Entry layout: {op[1:0], reg_addr[7:0], data[7:0]}
  localparam int unsigned EntryW  = 18;
  localparam int unsigned OpMsb   = 17;
  localparam int unsigned OpLsb   = 16;
  localparam int unsigned RegMsb  = 15;
  localparam int unsigned RegLsb  = 8;
  localparam int unsigned DataMsb = 7;
  localparam int unsigned DataLsb = 0;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Request/done handshake between the command sequencer and the I2C byte engine.
interface i2c_cmd_sequencer_if;
  logic       req;
  logic       rd;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       done;
  logic       nack;
  logic [7:0] rdata;

  modport master (
    output req, rd, dev_addr, reg_addr, wdata,
    input  done, nack, rdata
  );

  modport slave (
    input  req, rd, dev_addr, reg_addr, wdata,
    output done, nack, rdata
  );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; shared by the retry gap and delay waits.
module seq_down_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Synchronous reset, shared with the sequencer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Walks a command table and issues each WRITE/READ entry to the I2C byte engine,
// with NACK retry, timed delays, pass/fail reporting and last-read capture.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned AW         = 5,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned RETRY_GAP  = 1200,
  parameter int unsigned DELAY_UNIT = 12000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [AW-1:0]        tbl_addr,
  input  logic [EntryW-1:0]    tbl_data,
  i2c_cmd_sequencer_if.master  eng,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [AW-1:0]        fail_idx,
  output logic [7:0]           rd_data,
  output logic                 rd_valid
);

  localparam int unsigned DlyMax = 255 * DELAY_UNIT;
  localparam int unsigned CntMax = (DlyMax > RETRY_GAP) ? DlyMax : RETRY_GAP;
  localparam int unsigned CntW   = cnt_width(CntMax);
  localparam int unsigned RetryW = cnt_width(MAX_RETRY);

  state_e            state_q, state_d;
  logic [AW-1:0]     tbl_addr_q, tbl_addr_d;
  logic              req_q, req_d;
  logic              rd_q, rd_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [AW-1:0]     fail_idx_q, fail_idx_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [RetryW-1:0] retry_q, retry_d;

  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]   cnt_val;
  logic [31:0]       dly_cycles;
  op_e               op;
  logic [7:0]        ent_reg, ent_data;

  assign op         = op_e'(tbl_data[OpMsb:OpLsb]);
  assign ent_reg    = tbl_data[RegMsb:RegLsb];
  assign ent_data   = tbl_data[DataMsb:DataLsb];
  assign dly_cycles = 32'(ent_data) * DELAY_UNIT;

  always_comb begin
    state_d    = state_q;
    tbl_addr_d = tbl_addr_q;
    req_d      = req_q;
    rd_d       = rd_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    fail_idx_d = fail_idx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    retry_d    = retry_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tbl_addr_d = '0;
          error_d    = 1'b0;
          fail_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (op)
          OP_END: state_d = StDone;
          OP_DLY: begin
            if (ent_data == 8'd0) begin
              state_d = StNext;
            end else begin
              // Load N-1 so the DLY state lasts exactly N cycles.
              cnt_load = 1'b1;
              cnt_val  = CntW'(dly_cycles - 32'd1);
              state_d  = StDly;
            end
          end
          OP_WR, OP_RD: begin
            rd_d    = (op == OP_RD);
            reg_d   = ent_reg;
            wdata_d = ent_data;
            retry_d = '0;
            req_d   = 1'b1;
            state_d = StIssue;
          end
          default: state_d = StIdle;
        endcase
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (eng.done) begin
          req_d = 1'b0;
          if (!eng.nack) begin
            if (rd_q) begin
              rd_data_d  = eng.rdata;
              rd_valid_d = 1'b1;
            end
            state_d = StNext;
          end else if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d  = retry_q + RetryW'(1);
            cnt_load = 1'b1;
            cnt_val  = CntW'(RETRY_GAP - 1);
            state_d  = StGap;
          end else begin
            fail_idx_d = tbl_addr_q;
            error_d    = 1'b1;
            state_d    = StError;
          end
        end
      end
      StGap: begin
        if (cnt_zero) begin
          req_d   = 1'b1;
          state_d = StIssue;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDly: begin
        if (cnt_zero) begin
          state_d = StNext;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StNext: begin
        // Last entry acts as an implicit END; the pointer never wraps.
        if (tbl_addr_q == '1) begin
          state_d = StDone;
        end else begin
          tbl_addr_d = tbl_addr_q + AW'(1);
          state_d    = StFetch;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StError: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tbl_addr_q <= '0;
      req_q      <= 1'b0;
      rd_q       <= 1'b0;
      reg_q      <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      fail_idx_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      tbl_addr_q <= tbl_addr_d;
      req_q      <= req_d;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      fail_idx_q <= fail_idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      retry_q    <= retry_d;
    end
  end

  seq_down_counter #(
    .Width (CntW)
  ) u_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign tbl_addr     = tbl_addr_q;
  assign eng.req      = req_q;
  assign eng.rd       = rd_q;
  assign eng.dev_addr = DEV_ADDR;
  assign eng.reg_addr = reg_q;
  assign eng.wdata    = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign fail_idx     = fail_idx_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench: ROM and I2C engine models drive the sequencer; a
// table-walking reference model predicts transactions and outcomes.
module tb_i2c_cmd_sequencer;
  import i2c_seq_pkg::*;

  localparam int unsigned AW         = 4;
  localparam int unsigned N          = 16;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned RETRY_GAP  = 20;
  localparam int unsigned DELAY_UNIT = 10;
  localparam logic [6:0]  DEV        = 7'h50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [17:0]   tbl_data = '0;
  logic          busy, done, error, rd_valid;
  logic [AW-1:0] fail_idx;
  logic [7:0]    rd_data;

  i2c_cmd_sequencer_if eng ();

  i2c_cmd_sequencer #(
    .DEV_ADDR   (DEV),
    .AW         (AW),
    .MAX_RETRY  (MAX_RETRY),
    .RETRY_GAP  (RETRY_GAP),
    .DELAY_UNIT (DELAY_UNIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .eng      (eng),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .fail_idx (fail_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  logic [17:0] rom [N];
  logic [7:0]  rdmap [256];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_start = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int rv_cnt = 0;
  bit eng_en = 1'b1;
  bit nack_plan[$];
  bit req_prev = 1'b0;

  int            rise_cyc[$];
  int            fall_cyc[$];
  logic [AW-1:0] log_idx[$];
  bit            log_rd[$];
  logic [7:0]    log_reg[$];
  logic [7:0]    log_wd[$];

  logic [31:0]   exp_f[$];
  logic [7:0]    ref_rd = 8'd0;

  // Bus monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (eng.req && !req_prev) begin
      rise_cyc.push_back(cyc);
      log_idx.push_back(tbl_addr);
      log_rd.push_back(eng.rd);
      log_reg.push_back(eng.reg_addr);
      log_wd.push_back(eng.wdata);
    end
    if (!eng.req && req_prev) fall_cyc.push_back(cyc);
    req_prev = eng.req;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rd_valid) rv_cnt++;
  end

  // I2C engine model: random latency, NACKs taken from nack_plan in order.
  initial begin
    int lat;
    eng.done  = 1'b0;
    eng.nack  = 1'b0;
    eng.rdata = 8'd0;
    forever begin
      @(negedge clk);
      if (eng.req && eng_en) begin
        lat = $urandom_range(1, 4);
        repeat (lat) @(negedge clk);
        if (eng.req) begin
          eng.nack  = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
          eng.rdata = eng.rd ? rdmap[eng.reg_addr] : 8'($urandom);
          eng.done  = 1'b1;
          @(negedge clk);
          eng.done = 1'b0;
          eng.nack = 1'b0;
        end
      end
    end
  end

  function automatic logic [17:0] ent(logic [1:0] op, logic [7:0] r, logic [7:0] d);
    return {op, r, d};
  endfunction

  function automatic void clear_rom();
    for (int i = 0; i < N; i++) rom[i] = 18'd0;
  endfunction

  // Walks the table as the specification describes, consuming a copy of the
  // NACK plan, to predict every request, the outcome and the last read byte.
  task automatic model(output int en, output bit eerr, output int efail, output int erv);
    bit          plan[$];
    int          idx, tries;
    bit          fin, ok, nk;
    logic [17:0] e;
    plan = nack_plan;
    idx = 0; fin = 0; en = 0; eerr = 0; efail = 0; erv = 0;
    exp_f.delete();
    while (!fin) begin
      e = rom[idx];
      if (e[17:16] == 2'b00) begin
        fin = 1;
      end else if (e[17:16] != 2'b11) begin
        tries = 0; ok = 0;
        while (!ok && !eerr) begin
          nk = (plan.size() > 0) ? plan.pop_front() : 1'b0;
          en++;
          exp_f.push_back({8'd0, 4'(idx), 3'd0, e[17:16] == 2'b10, e[15:8], e[7:0]});
          if (!nk) begin
            ok = 1;
            if (e[17:16] == 2'b10) begin
              erv++;
              ref_rd = rdmap[e[15:8]];
            end
          end else if (tries < MAX_RETRY) begin
            tries++;
          end else begin
            eerr = 1;
            efail = idx;
          end
        end
        fin = eerr;
      end
      if (!fin) begin
        if (idx == N - 1) fin = 1;
        else idx++;
      end
    end
  endtask

  task automatic run(output bit to, output bit bsy);
    rise_cyc.delete(); fall_cyc.delete(); log_idx.delete();
    log_rd.delete(); log_reg.delete(); log_wd.delete();
    done_cnt = 0; rv_cnt = 0; done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    bsy = busy;
    for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
    to = busy;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, rd_valid, eng.req} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, error, rd_valid, eng.req});
    end
    n_cmp++;
    if ({fail_idx, rd_data, tbl_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: got %h want 0", {fail_idx, rd_data, tbl_addr});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    bit to, bsy;
    clear_rom();
    rom[0] = ent(2'b01, 8'h00, 8'hA5);
    run(to, bsy);
    n_cmp++;
    if (to || !bsy) begin n_fail++; $display("FAIL wr_busy: got to=%0b busy=%0b want 0/1", to, bsy); end
    n_cmp++;
    if (rise_cyc.size() != 1) begin
      n_fail++; $display("FAIL wr_req_count: got %0d want 1", rise_cyc.size());
    end else begin
      n_cmp++;
      if ({log_rd[0], log_reg[0], log_wd[0], eng.dev_addr} !== {1'b0, 8'h00, 8'hA5, DEV}) begin
        n_fail++;
        $display("FAIL wr_fields: got %h want %h", {log_rd[0], log_reg[0], log_wd[0], eng.dev_addr},
                 {1'b0, 8'h00, 8'hA5, DEV});
      end
    end
    n_cmp++;
    if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_status: got done=%0d err=%b busy=%b want 1/0/0", done_cnt, error, busy);
    end
    // A stray done while idle must be ignored.
    eng_en = 1'b0;
    @(negedge clk); eng.done = 1'b1; eng.rdata = 8'hFF;
    @(negedge clk); eng.done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rd_data !== ref_rd || busy !== 1'b0 || rv_cnt != 0) begin
      n_fail++; $display("FAIL stray_done: got rd=%h busy=%b rv=%0d want %h/0/0", rd_data, busy, rv_cnt, ref_rd);
    end
    eng_en = 1'b1;
  endtask

  task automatic test_read();
    bit to, bsy;
    clear_rom();
    rom[0] = ent(2'b10, 8'h00, 8'h00);
    rdmap[0] = 8'h3C;
    ref_rd = 8'h3C;
    run(to, bsy);
    n_cmp++;
    if (to || rv_cnt != 1 || rd_data !== 8'h3C) begin
      n_fail++; $display("FAIL rd_data: got to=%0b rv=%0d data=%h want 0/1/3c", to, rv_cnt, rd_data);
    end
    n_cmp++;
    if (rise_cyc.size() < 1 || rise_cyc[0] - t_start != 3) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d want 3", (rise_cyc.size() > 0) ? rise_cyc[0] - t_start : -1);
    end
  endtask

  task automatic test_retry();
    bit to, bsy;
    clear_rom();
    rom[0] = ent(2'b01, 8'($urandom), 8'($urandom));
    nack_plan = '{1'b1, 1'b1, 1'b0};
    run(to, bsy);
    n_cmp++;
    if (to || rise_cyc.size() != 3) begin
      n_fail++; $display("FAIL retry_count: got to=%0b reqs=%0d want 0/3", to, rise_cyc.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (rise_cyc[i+1] - fall_cyc[i] < int'(RETRY_GAP)) begin
          n_fail++; $display("FAIL retry_gap%0d: got %0d want >=%0d", i, rise_cyc[i+1] - fall_cyc[i], RETRY_GAP);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 1 || error !== 1'b0) begin
      n_fail++; $display("FAIL retry_status: got done=%0d err=%b want 1/0", done_cnt, error);
    end
  endtask

  task automatic test_error();
    bit to, bsy;
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = ent(2'b01, 8'(i), 8'($urandom));
    nack_plan = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    run(to, bsy);
    n_cmp++;
    if (to || rise_cyc.size() != 6) begin
      n_fail++; $display("FAIL err_reqs: got to=%0b reqs=%0d want 0/6", to, rise_cyc.size());
    end
    n_cmp++;
    if (error !== 1'b1 || fail_idx !== AW'(2) || done_cnt != 0) begin
      n_fail++; $display("FAIL err_status: got err=%b idx=%0d done=%0d want 1/2/0", error, fail_idx, done_cnt);
    end
    clear_rom();
    run(to, bsy);
    n_cmp++;
    if (to || error !== 1'b0 || fail_idx !== '0 || done_cnt != 1) begin
      n_fail++; $display("FAIL err_clear: got err=%b idx=%0d done=%0d want 0/0/1", error, fail_idx, done_cnt);
    end
  endtask

  task automatic test_delay();
    bit to, bsy;
    int lat;
    clear_rom();
    rom[0] = ent(2'b11, 8'h00, 8'd2);
    run(to, bsy);
    lat = done_cyc - t_start;
    n_cmp++;
    if (to || rise_cyc.size() != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL dly_run: got to=%0b reqs=%0d done=%0d want 0/0/1", to, rise_cyc.size(), done_cnt);
    end
    n_cmp++;
    if (lat < int'(2 * DELAY_UNIT) + 3 || lat > int'(2 * DELAY_UNIT) + 10) begin
      n_fail++; $display("FAIL dly_time: got %0d want %0d..%0d", lat, 2 * DELAY_UNIT + 3, 2 * DELAY_UNIT + 10);
    end
  endtask

  // Random tables; with_end=0 gives a full table with no END entry.
  task automatic test_random(input bit with_end, input int iters);
    bit to, bsy, eerr;
    int en, efail, erv;
    logic [1:0] op;
    logic [31:0] got;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < N; i++) begin
        op = 2'($urandom_range(1, 3));
        if (with_end && $urandom_range(0, 9) == 0) op = 2'b00;
        rom[i] = ent(op, 8'($urandom), (op == 2'b11) ? 8'($urandom_range(0, 2)) : 8'($urandom));
      end
      nack_plan.delete();
      for (int i = 0; i < 24; i++) nack_plan.push_back(with_end && $urandom_range(0, 3) == 0);
      model(en, eerr, efail, erv);
      run(to, bsy);
      nack_plan.delete();
      n_cmp++;
      if (to || rise_cyc.size() != en) begin
        n_fail++; $display("FAIL rand%0d_reqs: got to=%0b n=%0d want 0/%0d", it, to, rise_cyc.size(), en);
      end else begin
        for (int i = 0; i < en; i++) begin
          got = {8'd0, log_idx[i], 3'd0, log_rd[i], log_reg[i], log_wd[i]};
          n_cmp++;
          if (got !== exp_f[i]) begin
            n_fail++; $display("FAIL rand%0d_req%0d: got %h want %h", it, i, got, exp_f[i]);
          end
          if (i > 0) begin
            n_cmp++;
            if (rise_cyc[i] <= fall_cyc[i-1]) begin
              n_fail++; $display("FAIL rand%0d_lowgap%0d: got %0d want >0", it, i, rise_cyc[i] - fall_cyc[i-1]);
            end
          end
        end
      end
      n_cmp++;
      if (error !== eerr || done_cnt != int'(!eerr) || (eerr && fail_idx !== AW'(efail))) begin
        n_fail++;
        $display("FAIL rand%0d_status: got err=%b done=%0d idx=%0d want %b/%0d/%0d",
                 it, error, done_cnt, fail_idx, eerr, !eerr, efail);
      end
      n_cmp++;
      if (rv_cnt != erv || rd_data !== ref_rd) begin
        n_fail++; $display("FAIL rand%0d_rd: got rv=%0d data=%h want %0d/%h", it, rv_cnt, rd_data, erv, ref_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to, bsy;
    int k;
    clear_rom();
    rom[0] = ent(2'b01, 8'h12, 8'h34);
    eng_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (k = 0; k < 20 && !eng.req; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (eng.req !== 1'b1) begin n_fail++; $display("FAIL mid_req_up: got %b want 1", eng.req); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({eng.req, busy} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset: got req=%b busy=%b want 0/0", eng.req, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    eng_en = 1'b1;
    ref_rd = 8'd0;
    run(to, bsy);
    n_cmp++;
    if (to || rise_cyc.size() != 1 || done_cnt != 1) begin
      n_fail++; $display("FAIL mid_rerun: got to=%0b reqs=%0d done=%0d want 0/1/1", to, rise_cyc.size(), done_cnt);
    end else begin
      n_cmp++;
      if ({log_idx[0], log_reg[0], log_wd[0]} !== {AW'(0), 8'h12, 8'h34}) begin
        n_fail++; $display("FAIL mid_entry: got %h want %h", {log_idx[0], log_reg[0], log_wd[0]},
                           {AW'(0), 8'h12, 8'h34});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rdmap[i] = 8'($urandom);
    clear_rom();
    test_reset();
    test_write();
    test_read();
    test_retry();
    test_error();
    test_delay();
    test_random(1'b0, 3);
    test_random(1'b1, 6);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
